// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the fetch front-end: next-PC select codes, fetch FSM states
// and the NOP instruction presented before the first fetch completes.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10,
        S_TRAP  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC selection: sequential, conditional branch, JAL and JALR.
// All arithmetic wraps modulo 2^32.
module npc_gen
    import cpu_defs_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic        br_i,
    input  logic [31:0] ext_i,
    input  logic [31:0] rD1_i,
    output logic [31:0] npc_o
);

    always_comb begin
        npc_o = pc_i + 32'd4;
        case (npc_op_e'(npc_op_i))
            NPC_PC4:    npc_o = pc_i + 32'd4;
            NPC_BRANCH: if (br_i) npc_o = pc_i + ext_i;
            NPC_JAL:    npc_o = pc_i + ext_i;
            NPC_JALR:   npc_o = (rD1_i + ext_i) & ~32'h1;
            default:    npc_o = pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction register and the req/ack sequencing FSM toward the IROM.
// Optional INST_ALIGN_CHECK_EN: a misaligned retire target sets a sticky flag and parks in S_TRAP.
module instruction_fetch
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              irom_req_o,
    output logic [ADDR_W-1:0] irom_addr_o,
    input  logic              irom_ack_i,
    input  logic [31:0]       irom_data_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic [1:0]        npc_op_i,
    input  logic              br_i,
    input  logic [31:0]       ext_i,
    input  logic [31:0]       rD1_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc4_o,
    output logic              misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  npc;

    npc_gen u_npc_gen (
        .pc_i     (pc_q),
        .npc_op_i (npc_op_i),
        .br_i     (br_i),
        .ext_i    (ext_i),
        .rD1_i    (rD1_i),
        .npc_o    (npc)
    );

`ifdef INST_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

`ifdef INST_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) misalign_q <= 1'b0;
        else          misalign_q <= misalign_d;
    end
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef INST_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (irom_ack_i) begin
                    inst_d  = irom_data_i;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready_i) begin
                    pc_d    = npc;
                    state_d = S_FETCH;
`ifdef INST_ALIGN_CHECK_EN
                    if (npc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_TRAP;
                    end
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Request is decoded from the state register so an async reset drops it at once.
    assign irom_req_o   = (state_q == S_FETCH);
    assign irom_addr_o  = pc_q[ADDR_W+1:2];
    assign inst_valid_o = (state_q == S_VALID);
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign pc4_o        = pc_q + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, a vector table and a
// randomized run against a transaction-level PC/ROM model.
module tb_instruction_fetch;

    localparam int AW = 14;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          irom_req_o;
    logic [AW-1:0] irom_addr_o;
    logic          irom_ack_i;
    logic [31:0]   irom_data_i;
    logic [31:0]   inst_o;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic [1:0]    npc_op_i;
    logic          br_i;
    logic [31:0]   ext_i;
    logic [31:0]   rD1_i;
    logic [31:0]   pc_o;
    logic [31:0]   pc4_o;
    logic          misalign_o;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .irom_req_o   (irom_req_o),
        .irom_addr_o  (irom_addr_o),
        .irom_ack_i   (irom_ack_i),
        .irom_data_i  (irom_data_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .npc_op_i     (npc_op_i),
        .br_i         (br_i),
        .ext_i        (ext_i),
        .rD1_i        (rD1_i),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc = 32'h0;
    int          ack_delay = 0;
    bit          ack_rand  = 1'b0;
    int          req_cnt   = 0;

    typedef struct {
        logic [1:0]  op;
        logic        br;
        logic [31:0] ext;
        logic [31:0] rd1;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        return ({18'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] op,
                                              input logic br, input logic [31:0] ext,
                                              input logic [31:0] rd1);
        logic [31:0] base;
        case (op)
            2'd0:    return pc + 4;
            2'd1:    return br ? pc + ext : pc + 4;
            2'd2:    return pc + ext;
            default: begin
                base = rd1 + ext;
                return {base[31:1], 1'b0};
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: advance to the next falling edge, then play the IROM side.
    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
        if (irom_req_o) begin
            req_cnt++;
            chk("req_addr", {18'h0, irom_addr_o}, {18'h0, m_pc[AW+1:2]});
            if (ack_rand) irom_ack_i = ($urandom_range(0, 1) == 1) || (req_cnt > 8);
            else          irom_ack_i = (req_cnt > ack_delay);
            irom_data_i = irom_ack_i ? rom(irom_addr_o) : $urandom();
        end else begin
            req_cnt     = 0;
            irom_ack_i  = ($urandom_range(0, 3) == 0);
            irom_data_i = $urandom();
        end
    endtask

    task automatic wait_valid(input string name, input int max, output int cyc);
        cyc = 0;
        while (!inst_valid_o && cyc < max) begin
            cycle();
            cyc++;
        end
        chk(name, {31'h0, inst_valid_o}, 32'h1);
    endtask

    task automatic check_inst(input string tag);
        chk({tag, "_pc"},   pc_o,   m_pc);
        chk({tag, "_pc4"},  pc4_o,  m_pc + 4);
        chk({tag, "_inst"}, inst_o, rom(m_pc[AW+1:2]));
    endtask

    task automatic retire(input logic [1:0] op, input logic br, input logic [31:0] ext,
                          input logic [31:0] rd1);
        inst_ready_i = 1'b1;
        npc_op_i = op; br_i = br; ext_i = ext; rD1_i = rd1;
        m_pc = model_npc(m_pc, op, br, ext, rd1);
        cycle();
        inst_ready_i = 1'b0;
        npc_op_i = 2'($urandom()); br_i = 1'($urandom()); ext_i = $urandom(); rD1_i = $urandom();
    endtask

    vec_t vecs[10];
    int   cyc;
    int   idle;
    bit   bad;

    initial begin
        vecs[0] = '{2'd0, 1'b0, 32'h0,         32'h0,         32'h0000_0010, 32'h0000_0014};
        vecs[1] = '{2'd2, 1'b0, 32'h0000_00F0, 32'h0,         32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F0, 32'h0000_00F4};
        vecs[3] = '{2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0100, 32'h0000_0104};
        vecs[4] = '{2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0000_0104, 32'h0000_0108};
        vecs[5] = '{2'd3, 1'b0, 32'h0000_0004, 32'h0000_2001, 32'h0000_2004, 32'h0000_2008};
        vecs[6] = '{2'd3, 1'b0, 32'h0000_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[7] = '{2'd0, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0004};
        vecs[8] = '{2'd2, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFF4};
        vecs[9] = '{2'd3, 1'b1, 32'h0000_0020, 32'h0000_1000, 32'h0000_1020, 32'h0000_1024};

        reset_i = 1'b0; irom_ack_i = 1'b0; irom_data_i = '0; inst_ready_i = 1'b0;
        npc_op_i = '0; br_i = 1'b0; ext_i = '0; rD1_i = '0;
        repeat (3) @(negedge clk_i);

        // Reset state
        chk("rst_req",      {31'h0, irom_req_o},   32'h0);
        chk("rst_valid",    {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst",     inst_o,                32'h0000_0013);
        chk("rst_pc",       pc_o,                  32'h0);
        chk("rst_misalign", {31'h0, misalign_o},   32'h0);

        // 1: zero-wait ROM, ready every valid
        reset_i = 1'b1;
        cycle();
        chk("first_req", {31'h0, irom_req_o}, 32'h1);
        wait_valid("first_valid", 10, cyc);
        chk("first_lat", cyc, 1);
        for (int i = 0; i < 3; i++) begin
            check_inst("seq");
            if (i < 2) begin
                retire(2'd0, 1'b0, 32'h0, 32'h0);
                wait_valid("seq_valid", 10, cyc);
                chk("seq_period", cyc + 1, 2);
            end
        end

        // 2: three wait states
        ack_delay = 3;
        retire(2'd0, 1'b0, 32'h0, 32'h0);
        wait_valid("wait_valid", 20, cyc);
        chk("wait_lat", cyc + 1, 5);
        check_inst("wait");
        ack_delay = 0;

        // Vector table of next-PC operations
        for (int unsigned i = 0; i < 10; i++) begin
            retire(vecs[i].op, vecs[i].br, vecs[i].ext, vecs[i].rd1);
            wait_valid("vec_valid", 10, cyc);
            chk($sformatf("vec%0d_pc", i),  pc_o,  vecs[i].exp_pc);
            chk($sformatf("vec%0d_pc4", i), pc4_o, vecs[i].exp_pc4);
            chk($sformatf("vec%0d_inst", i), inst_o, rom(vecs[i].exp_pc[AW+1:2]));
        end

        // 5: reset during an outstanding fetch
        ack_delay = 6;
        retire(2'd0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("mid_req_before", {31'h0, irom_req_o}, 32'h1);
        reset_i = 1'b0;
        #1;
        chk("mid_req_drop", {31'h0, irom_req_o}, 32'h0);
        chk("mid_pc", pc_o, 32'h0);
        m_pc = 32'h0;
        ack_delay = 0;
        cycle();
        cycle();
        reset_i = 1'b1;
        cycle();
        chk("restart_req", {31'h0, irom_req_o}, 32'h1);
        wait_valid("restart_valid", 10, cyc);
        check_inst("restart");

        // Randomized run against the model
        ack_rand = 1'b1;
        idle = 0;
        for (int i = 0; i < 400; i++) begin
            if (inst_valid_o) begin
                check_inst("rnd");
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 30) begin
                chk("rnd_timeout", {31'h0, inst_valid_o}, 32'h1);
                break;
            end
            inst_ready_i = ($urandom_range(0, 2) == 0);
            npc_op_i = 2'($urandom()); br_i = 1'($urandom());
            ext_i = $urandom() & ~32'h3; rD1_i = $urandom() & ~32'h3;
            if (inst_valid_o && inst_ready_i)
                m_pc = model_npc(m_pc, npc_op_i, br_i, ext_i, rD1_i);
            cycle();
        end
        inst_ready_i = 1'b0;
        ack_rand = 1'b0;
        wait_valid("rnd_end_valid", 20, cyc);
        check_inst("rnd_end");

        // 6: misaligned JAL target
        retire(2'd2, 1'b0, 32'h0000_0002, 32'h0);
`ifdef INST_ALIGN_CHECK_EN
        chk("trap_misalign", {31'h0, misalign_o}, 32'h1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (irom_req_o || inst_valid_o) bad = 1'b1;
            inst_ready_i = 1'($urandom());
            cycle();
        end
        inst_ready_i = 1'b0;
        chk("trap_quiet", {31'h0, bad}, 32'h0);
        chk("trap_sticky", {31'h0, misalign_o}, 32'h1);
        reset_i = 1'b0;
        #1;
        chk("trap_clear", {31'h0, misalign_o}, 32'h0);
        cycle();
        reset_i = 1'b1;
`else
        bad = 1'b0;
        chk("noalign_misalign", {31'h0, misalign_o}, 32'h0);
        wait_valid("noalign_valid", 10, cyc);
        check_inst("noalign");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
